// File: rtl/wall_height_stage.sv
// wall_height_stage: scales a Q(M).(N) reciprocal distance by HEIGHT_SCALE,
// clamps the result to SCREEN_H and emits the wall height with its top/bottom
// rows. Two register stages (S1 multiply, S2 clamp/place) use valid/ready on
// both sides. A clamp counter tracks clamped columns per frame.
// Optional macro WALL_HEIGHT_ROUND_EN: round-to-nearest (ties up) instead of truncation.
module wall_height_stage #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int COL_BITS     = 10,
  parameter int ROW_BITS     = 10,
  parameter int SCREEN_H     = 480,
  parameter int HEIGHT_SCALE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_frame_start,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [COL_BITS-1:0] i_col,
  input  logic [M+N-1:0]      i_recip,
  input  logic                i_sat,
  input  logic                i_side,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [COL_BITS-1:0] o_col,
  output logic                o_side,
  output logic [ROW_BITS-1:0] o_height,
  output logic [ROW_BITS-1:0] o_top,
  output logic [ROW_BITS-1:0] o_bottom,
  output logic                o_clamped,
  output logic [COL_BITS:0]   o_clamp_count
);

  localparam int PW = M + N + 16;
  localparam int IW = M + 16;
  localparam logic [IW:0]         H_LIMIT = (IW+1)'(SCREEN_H);
  localparam logic [ROW_BITS-1:0] H_MAX   = ROW_BITS'(SCREEN_H);

  // S1 state
  logic                s1_valid_q, s1_valid_d;
  logic [IW-1:0]       s1_int_q, s1_int_d;
  logic                s1_sat_q, s1_sat_d;
  logic [COL_BITS-1:0] s1_col_q, s1_col_d;
  logic                s1_side_q, s1_side_d;
`ifdef WALL_HEIGHT_ROUND_EN
  logic                s1_frac_q, s1_frac_d;
`endif

  // S2 state (drives the outputs directly)
  logic                s2_valid_q, s2_valid_d;
  logic [COL_BITS-1:0] s2_col_q, s2_col_d;
  logic                s2_side_q, s2_side_d;
  logic [ROW_BITS-1:0] s2_height_q, s2_height_d;
  logic [ROW_BITS-1:0] s2_top_q, s2_top_d;
  logic [ROW_BITS-1:0] s2_bottom_q, s2_bottom_d;
  logic                s2_clamped_q, s2_clamped_d;

  logic [COL_BITS:0]   cnt_q, cnt_d;

  logic                s1_load, s2_load, hs_clamped, clamp;
  logic [PW-1:0]       prod;
  logic [IW:0]         h_raw;
  logic [ROW_BITS-1:0] h;

  // Handshake, multiply, clamp/place and counter next-state logic
  always_comb begin
    s2_load = !s2_valid_q || i_ready;
    s1_load = !s1_valid_q || s2_load;
    o_ready = s1_load;

    prod     = PW'(i_recip) * PW'(HEIGHT_SCALE);
    s1_int_d = s1_int_q;
    s1_sat_d = s1_sat_q;
    s1_col_d = s1_col_q;
    s1_side_d = s1_side_q;
`ifdef WALL_HEIGHT_ROUND_EN
    s1_frac_d = s1_frac_q;
`endif
    s1_valid_d = s1_load ? i_valid : s1_valid_q;
    if (s1_load && i_valid) begin
      s1_int_d  = IW'(prod >> N);
      s1_sat_d  = i_sat;
      s1_col_d  = i_col;
      s1_side_d = i_side;
`ifdef WALL_HEIGHT_ROUND_EN
      s1_frac_d = prod[N-1];
`endif
    end

`ifdef WALL_HEIGHT_ROUND_EN
    h_raw = {1'b0, s1_int_q} + (IW+1)'(s1_frac_q);
`else
    h_raw = {1'b0, s1_int_q};
`endif
    clamp = s1_sat_q || (h_raw > H_LIMIT);
    h     = clamp ? H_MAX : h_raw[ROW_BITS-1:0];

    s2_valid_d   = s2_load ? s1_valid_q : s2_valid_q;
    s2_col_d     = s2_col_q;
    s2_side_d    = s2_side_q;
    s2_height_d  = s2_height_q;
    s2_top_d     = s2_top_q;
    s2_bottom_d  = s2_bottom_q;
    s2_clamped_d = s2_clamped_q;
    // Data only moves with a real beat so outputs never change under a bubble
    if (s2_load && s1_valid_q) begin
      s2_col_d     = s1_col_q;
      s2_side_d    = s1_side_q;
      s2_height_d  = h;
      s2_top_d     = (H_MAX - h) >> 1;
      s2_bottom_d  = ((H_MAX - h) >> 1) + h;
      s2_clamped_d = clamp;
    end

    // Frame start wins over increment, but a coinciding clamped beat belongs to the new frame
    hs_clamped = s2_valid_q && i_ready && s2_clamped_q;
    cnt_d      = cnt_q;
    if (i_frame_start)
      cnt_d = (COL_BITS+1)'(hs_clamped);
    else if (hs_clamped && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_int_q     <= '0;
      s1_sat_q     <= 1'b0;
      s1_col_q     <= '0;
      s1_side_q    <= 1'b0;
`ifdef WALL_HEIGHT_ROUND_EN
      s1_frac_q    <= 1'b0;
`endif
      s2_valid_q   <= 1'b0;
      s2_col_q     <= '0;
      s2_side_q    <= 1'b0;
      s2_height_q  <= '0;
      s2_top_q     <= '0;
      s2_bottom_q  <= '0;
      s2_clamped_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_int_q     <= s1_int_d;
      s1_sat_q     <= s1_sat_d;
      s1_col_q     <= s1_col_d;
      s1_side_q    <= s1_side_d;
`ifdef WALL_HEIGHT_ROUND_EN
      s1_frac_q    <= s1_frac_d;
`endif
      s2_valid_q   <= s2_valid_d;
      s2_col_q     <= s2_col_d;
      s2_side_q    <= s2_side_d;
      s2_height_q  <= s2_height_d;
      s2_top_q     <= s2_top_d;
      s2_bottom_q  <= s2_bottom_d;
      s2_clamped_q <= s2_clamped_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_valid       = s2_valid_q;
  assign o_col         = s2_col_q;
  assign o_side        = s2_side_q;
  assign o_height      = s2_height_q;
  assign o_top         = s2_top_q;
  assign o_bottom      = s2_bottom_q;
  assign o_clamped     = s2_clamped_q;
  assign o_clamp_count = cnt_q;

endmodule

// File: tb/tb_wall_height_stage.sv
// Scoreboard bench for wall_height_stage: a driver pushes expected beats
// from an arithmetic reference model; a monitor pops and compares on each
// output handshake, tracks the clamp count and checks stall stability.
module tb_wall_height_stage;

  localparam int SH    = 480;
  localparam int SCALE = 256;

  logic        clk, reset, i_frame_start, i_valid, o_ready, i_sat, i_side;
  logic        o_valid, i_ready, o_side, o_clamped;
  logic [9:0]  i_col, o_col, o_height, o_top, o_bottom;
  logic [31:0] i_recip;
  logic [10:0] o_clamp_count;

  wall_height_stage #(
    .M(16), .N(16), .COL_BITS(10), .ROW_BITS(10),
    .SCREEN_H(SH), .HEIGHT_SCALE(SCALE)
  ) dut (
    .clk(clk), .reset(reset), .i_frame_start(i_frame_start),
    .i_valid(i_valid), .o_ready(o_ready), .i_col(i_col), .i_recip(i_recip),
    .i_sat(i_sat), .i_side(i_side), .o_valid(o_valid), .i_ready(i_ready),
    .o_col(o_col), .o_side(o_side), .o_height(o_height), .o_top(o_top),
    .o_bottom(o_bottom), .o_clamped(o_clamped), .o_clamp_count(o_clamp_count)
  );

  typedef struct packed {
    logic [9:0] col;
    logic       side;
    logic [9:0] h;
    logic [9:0] top;
    logic [9:0] bot;
    logic       clamped;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned pass_cnt = 0, total_cnt = 0;
  int unsigned mcnt = 0, hs_total = 0, cyc = 0;
  bit          rdy_rand = 0, rdy_force = 1, fs_rand = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: forced or random, changed just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // Reference: height = floor(recip * scale / 2^16), optionally rounded, clamped to SH
  function automatic exp_t model(input logic [31:0] r, input logic s,
                                 input logic [9:0] c, input logic sd);
    logic [63:0] p, ip;
    int unsigned hh;
    exp_t e;
    p  = 64'(r) * 64'(SCALE);
    ip = p >> 16;
`ifdef WALL_HEIGHT_ROUND_EN
    ip = ip + ((p >> 15) & 64'd1);
`endif
    e.clamped = s || (ip > 64'(SH));
    hh    = e.clamped ? SH : 32'(ip);
    e.h   = 10'(hh);
    e.top = 10'((SH - hh) / 2);
    e.bot = 10'((SH - hh) / 2 + hh);
    e.col = c;
    e.side = sd;
    return e;
  endfunction

  // Monitor: count, stall stability, scoreboard pop on handshake
  initial begin
    exp_t cur, held, e;
    bit hold, hs_cl;
    hold = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 0;
        continue;
      end
      chk("clamp_count", 64'(o_clamp_count), 64'(mcnt));
      cur = {o_col, o_side, o_height, o_top, o_bottom, o_clamped};
      if (hold) chk("hold_stable", 64'(cur), 64'(held));
      hs_cl = 0;
      if (o_valid && i_ready) begin
        hs_total++;
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(cur), 64'hdead);
        else begin
          e = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(e));
          hs_cl = e.clamped;
        end
      end
      hold = o_valid && !i_ready;
      held = cur;
      if (i_frame_start) mcnt = hs_cl ? 1 : 0;
      else if (hs_cl && mcnt < 2047) mcnt++;
    end
  end

  task automatic send(input logic [31:0] r, input logic s, input logic [9:0] c, input logic sd);
    bit acc;
    acc = 0;
    i_valid = 1; i_recip = r; i_sat = s; i_col = c; i_side = sd;
    for (int k = 0; k < 200 && !acc; k++) begin
      i_frame_start = fs_rand && ($urandom_range(0, 19) == 0);
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    i_frame_start = 0;
    if (acc) exp_q.push_back(model(r, s, c, sd));
    else chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_frame_start = fs_rand && ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    i_frame_start = 0;
  endtask

  task automatic pulse_fs();
    i_frame_start = 1;
    @(posedge clk);
    #1;
    i_frame_start = 0;
  endtask

  // Single beat into an empty pipe: checks 2-cycle latency and fixed result values
  task automatic sendlat(input logic [31:0] r, input logic [9:0] c,
                         input int eh, input int et, input int eb);
    send(r, 1'b0, c, 1'b0);
    @(negedge clk);
    chk("lat_not_yet", 64'(o_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("lat_height", 64'(o_height), 64'(eh));
    chk("lat_top", 64'(o_top), 64'(et));
    chk("lat_bottom", 64'(o_bottom), 64'(eb));
    chk("lat_col", 64'(o_col), 64'(c));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int unsigned t0, h0;
    reset = 1; i_frame_start = 0; i_valid = 0; i_recip = 0; i_sat = 0;
    i_col = 0; i_side = 0; i_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_count", 64'(o_clamp_count), 64'd0);
    chk("rst_height", 64'(o_height), 64'd0);
    reset = 0;
    idle(1);

    sendlat(32'h0000_8000, 10'd5, 128, 176, 304);

    // Clamp cases and count clear
    pulse_fs();
    send(32'h0000_0010, 1'b1, 10'd6, 1'b1);
    send(32'h0002_0000, 1'b0, 10'd7, 1'b0);
    idle(4);
    chk("count_two", 64'(o_clamp_count), 64'd2);
    pulse_fs();
    @(negedge clk);
    chk("count_cleared", 64'(o_clamp_count), 64'd0);
    @(posedge clk);
    #1;

    // Frame start coinciding with a clamped handshake leaves count at 1
    send(32'h0, 1'b1, 10'd8, 1'b0);
    idle(4);
    send(32'h0, 1'b1, 10'd9, 1'b0);
    @(posedge clk);
    #1;
    i_frame_start = 1;
    @(posedge clk);
    #1;
    i_frame_start = 0;
    @(negedge clk);
    chk("count_coincide", 64'(o_clamp_count), 64'd1);
    idle(3);

`ifdef WALL_HEIGHT_ROUND_EN
    sendlat(32'h0000_0180, 10'd10, 2, 239, 241);
`else
    sendlat(32'h0000_0180, 10'd10, 1, 239, 240);
`endif
    sendlat(32'h0000_0000, 10'd11, 0, 240, 240);

    // Backpressure: fill both stages, ready must drop and outputs hold
    rdy_force = 0;
    idle(1);
    send(32'h0000_4000, 1'b0, 10'd0, 1'b0);
    send(32'h0000_6000, 1'b0, 10'd1, 1'b1);
    i_valid = 1; i_recip = 32'h0000_7000; i_sat = 0; i_col = 10'd2; i_side = 0;
    @(negedge clk);
    chk("bp_ready_low", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_low2", 64'(o_ready), 64'd0);
    rdy_force = 1;
    @(posedge clk);
    #1;
    send(32'h0000_7000, 1'b0, 10'd2, 1'b0);
    send(32'h0000_9000, 1'b0, 10'd3, 1'b1);
    idle(4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Throughput: one beat per cycle
    t0 = cyc; h0 = hs_total;
    for (int i = 0; i < 20; i++) send($urandom_range(0, 32'h1_FFFF), 1'b0, 10'(i), 1'b0);
    chk("tput_in", 64'(cyc - t0), 64'd20);
    chk("tput_out", 64'(hs_total - h0), 64'd18);
    idle(3);
    chk("tput_total", 64'(hs_total - h0), 64'd20);

    // Mid-operation reset with both stages full
    rdy_force = 0;
    idle(1);
    send(32'h0000_5000, 1'b1, 10'd20, 1'b0);
    send(32'h0000_5000, 1'b0, 10'd21, 1'b0);
    idle(1);
    #2;
    reset = 1;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    chk("midrst_count", 64'(o_clamp_count), 64'd0);
    exp_q.delete();
    mcnt = 0;
    rdy_force = 1;
    @(posedge clk);
    #1;
    reset = 0;
    idle(2);
    sendlat(32'h0001_0000, 10'd22, 256, 112, 368);

    // Randomized traffic
    rdy_rand = 1;
    fs_rand = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: r = $urandom;
        1: r = $urandom_range(0, 255);
        default: r = $urandom_range(0, 32'h2_0000);
      endcase
      send(r, $urandom_range(0, 7) == 0, 10'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    rdy_rand = 0;
    fs_rand = 0;
    idle(4);

    // Counter saturation
    for (int i = 0; i < 2060; i++) send($urandom, 1'b1, 10'(i), 1'b0);
    idle(4);
    chk("count_saturated", 64'(o_clamp_count), 64'd2047);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
